// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: single-outstanding load/store responder in front of a word-wide RAM.
// Latency: a request accepted at edge N commits on edge N+LATENCY; resp_valid is sampled high at edge N+1+LATENCY.
// Backpressure: one transaction in flight; req_ready stays low from acceptance until the response handshake.
// Optional: define CPU_MEM_RESPONDER_STATS_EN to add saturating stat_reads/stat_writes/stat_errs counters.
module cpu_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [3:0]            req_wstrb,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
`ifdef CPU_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes,
  output logic [31:0]           stat_errs
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit         LAT_ZERO = (LATENCY == 0);
  localparam logic [3:0] LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  // Backing store; deliberately never reset so contents survive a reset pulse.
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_from_req;
  logic [ADDR_WIDTH-1:0] w_c_addr;
  logic                  w_c_we;
  logic [3:0]            w_c_wstrb;
  logic [31:0]           w_c_wdata;
  logic                  w_misalign;
  logic                  w_oob;
  logic                  w_err;
  logic [IDX_W-1:0]      w_idx;
  logic [31:0]           w_rd_word;

  assign req_ready  = reset && (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  assign w_accept = req_valid && req_ready;

  // With zero wait states the access commits on the acceptance edge itself,
  // so the commit operands come straight from the request port in that case.
  assign w_from_req = LAT_ZERO && (r_state == ST_IDLE);
  assign w_commit   = reset && ((LAT_ZERO && (r_state == ST_IDLE) && w_accept) ||
                                ((r_state == ST_WAIT) && (r_cnt == 4'd0)));

  assign w_c_addr  = w_from_req ? req_addr  : r_addr;
  assign w_c_we    = w_from_req ? req_we    : r_we;
  assign w_c_wstrb = w_from_req ? req_wstrb : r_wstrb;
  assign w_c_wdata = w_from_req ? req_wdata : r_wdata;

  // Range check uses every upper address bit so high addresses never alias low words.
  assign w_misalign = (w_c_addr[1:0] != 2'b00);
  assign w_oob      = ({2'b00, w_c_addr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(DEPTH_WORDS));
  assign w_err      = w_misalign || w_oob;
  assign w_idx      = w_c_addr[IDX_W+1:2];
  assign w_rd_word  = r_mem[w_idx];

  // Control FSM plus request capture and response register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wstrb <= 4'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_we    <= req_we;
            r_wstrb <= req_wstrb;
            r_wdata <= req_wdata;
            r_cnt   <= LAT_M1;
            r_state <= LAT_ZERO ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state <= ST_IDLE;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_commit) begin
        r_rdata <= (!w_err && !w_c_we) ? w_rd_word : 32'd0;
        r_err   <= w_err;
      end
    end
  end

  // Byte-lane store into the RAM on a clean committing write; kept reset-free for RAM inference.
  always_ff @(posedge clk) begin
    if (w_commit && w_c_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_c_wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
        end
      end
    end
  end

`ifdef CPU_MEM_RESPONDER_STATS_EN
  logic [31:0] r_stat_reads;
  logic [31:0] r_stat_writes;
  logic [31:0] r_stat_errs;

  assign stat_reads  = r_stat_reads;
  assign stat_writes = r_stat_writes;
  assign stat_errs   = r_stat_errs;

  // Saturating per-class access counters, bumped on the commit edge only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_reads  <= 32'd0;
      r_stat_writes <= 32'd0;
      r_stat_errs   <= 32'd0;
    end else if (w_commit) begin
      if (w_err) begin
        if (r_stat_errs != 32'hFFFF_FFFF) r_stat_errs <= r_stat_errs + 32'd1;
      end else if (w_c_we) begin
        if (r_stat_writes != 32'hFFFF_FFFF) r_stat_writes <= r_stat_writes + 32'd1;
      end else begin
        if (r_stat_reads != 32'hFFFF_FFFF) r_stat_reads <= r_stat_reads + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
Memory-side responder for the RV32 core's load/store bus, sitting at the far end of the CPU's data-memory request interface.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states.
- Returns read data or a write acknowledgement over a valid/ready response channel.
- Backs the core in simulation and synthesises to an inferred word-wide RAM.

Parameters:
- ADDR_WIDTH, 32: byte-address width of req_addr.
- DEPTH_WORDS, 1024: number of 32-bit words in the backing array.
- LATENCY, 2: wait-state cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_WIDTH  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_wstrb  in  4  byte-lane write enables; ignored for loads.
- req_wdata  in  32  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  CPU accepts the response.
- resp_rdata  out  32  load data; 0 for stores and for errors.
- resp_err  out  1  misaligned or out-of-range access.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (reset==0 at a clk edge):
  - state goes to IDLE, wait counter to 0.
  - req_ready=0 during reset; resp_valid=0, resp_rdata=0, resp_err=0.
  - Memory contents are not cleared.
  - Reset mid-operation abandons the transaction. A store still in WAIT is dropped and never written.
- IDLE:
  - req_ready=1.
  - Acceptance happens when req_valid && req_ready at an edge.
  - On acceptance, latch addr, we, wstrb and wdata.
  - Next state is WAIT if LATENCY>0, otherwise RESP. Counter is loaded with LATENCY-1.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter is 0, the access commits and the state moves to RESP.
- Commit: performed on the edge entering RESP.
  - err = (addr[1:0]!=0) or (addr[ADDR_WIDTH-1:2] >= DEPTH_WORDS).
  - Load with no error: resp_rdata <= mem[addr>>2].
  - Store with no error: write each byte lane i where wstrb[i]=1; resp_rdata <= 0.
  - Error: no memory write, resp_rdata <= 0, resp_err <= 1.
  - Store with wstrb==0: legal no-op, err=0.
- RESP:
  - resp_valid=1, req_ready=0.
  - rdata and err are held stable until resp_ready=1 at an edge, then the state returns to IDLE.
  - No combinational path from req_* to resp_*.
- Latency: a request accepted at edge N gives resp_valid high after edge N+1+LATENCY.
  - The earliest next acceptance is one cycle after the response handshake.
  - Minimum throughput is one transaction per LATENCY+2 cycles.
- Back-to-back: a new request held valid while in RESP is not accepted until IDLE. req_valid may stay high throughout.
- req_valid dropped before acceptance: nothing happens.
- Read-after-write to the same address returns the new data.
- Width: the upper address bits beyond the word index are included in the range check, never truncated.

Optional Feature:
- Macro: CPU_MEM_RESPONDER_STATS_EN.
- Defined: adds three outputs, stat_reads, stat_writes and stat_errs, each 32 bits.
  - Each counter increments by 1 on the commit edge of a matching access: non-error load, non-error store, or any error.
  - Error accesses count only in stat_errs.
  - Counters saturate at 32'hFFFFFFFF.
  - All counters reset to 0 on reset==0.
- Undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF. Then load 0x10 → resp_valid rises exactly 3 cycles after each acceptance; load returns 0xDEADBEEF, err=0.
- Byte strobes:
  - Store 0x11223344 to 0x20 with wstrb 4'hF, then store 0xAABBCCDD with wstrb 4'b0101.
  - Load 0x20 → 0x11BB33DD.
- Errors:
  - Load 0x22 → err=1, rdata=0.
  - Store to byte address 4*DEPTH_WORDS (0x1000) → err=1.
  - A subsequent load 0x0 confirms no wrap-around write.
- Backpressure: hold resp_ready=0 for 5 cycles with req_valid=1 continuously → resp_valid stays 1 with stable data, req_ready stays 0, and the second request is accepted only after the handshake.
- Reset mid-WAIT: store 0x55 to 0x30, then pull reset low for 1 cycle during WAIT → outputs read 0 and the state is IDLE; load 0x30 returns its prior value.
- LATENCY=0 build: load → resp_valid 1 cycle after acceptance. With CPU_MEM_RESPONDER_STATS_EN defined, 2 loads, 1 store and 1 error give stat_reads=2, stat_writes=1, stat_errs=1.
